hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard sequencer for the five-stage MIPS datapath. Sits beside the forwarding unit and handles the hazards that forwarding cannot: load-use hazards (one or more bubbles), taken-branch flushes resolved in MEM, and variable-latency data-memory waits that freeze the whole pipeline. It drives the PC and pipeline-register write enables and flushes, and keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (≥1).
- WAIT_W, 8: width of the memory-wait counter.
- MEM_TIMEOUT, 255: wait cycles before MemTimeout sets (< 2^WAIT_W).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- IdRs  in  5  rs of the instruction in ID.
- IdRt  in  5  rt of the instruction in ID.
- IdUsesRt  in  1  ID instruction reads rt as a source.
- ExeRt  in  5  destination rt of the instruction in EX.
- ExeMemRead  in  1  EX instruction is a load.
- BranchTaken  in  1  branch in MEM resolved taken.
- MemReq  in  1  MEM stage is accessing data memory this cycle.
- MemReady  in  1  data memory completes the access this cycle.
- PcWrite  out  1  PC register enable.
- IfIdWrite  out  1  IF/ID enable.
- IfIdFlush  out  1  clear IF/ID to NOP.
- IdExFlush  out  1  clear ID/EX control fields (bubble).
- ExMemFlush  out  1  clear EX/MEM control fields.
- StageEn  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- MemTimeout  out  1  sticky memory-timeout error.
- StallCnt  out  16  saturating count of cycles with PcWrite=0.

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Registers: state, ret_state, bub_cnt, wait_cnt, MemTimeout, StallCnt.
- Control outputs are combinational from state and inputs. Defaults: PcWrite=1, IfIdWrite=1, StageEn=1, flushes=0.
- freeze = MemReq & ~MemReady. Priority, highest first: freeze > BranchTaken > load-use.
- freeze, any state: PcWrite=IfIdWrite=StageEn=0 and all flushes 0.
  - Not in MEM_WAIT: ret_state←state, wait_cnt←1, state←MEM_WAIT.
  - bub_cnt holds while frozen.
- MEM_WAIT with MemReady=1: freeze drops that cycle, outputs are computed as in ret_state, and state←ret_state.
- MEM_WAIT with MemReady=0: wait_cnt increments, saturating.
  - When wait_cnt==MEM_TIMEOUT, MemTimeout←1. It is cleared only by reset.
  - The state stays MEM_WAIT.
- BranchTaken (not frozen): PcWrite=1, IfIdFlush=IdExFlush=ExMemFlush=1, state←RUN, bub_cnt←0. Any LU_STALL is aborted.
- load_use = ExeMemRead & ExeRt≠0 & (ExeRt==IdRs | (IdUsesRt & ExeRt==IdRt)). It is evaluated in RUN only.
- RUN with load_use: PcWrite=0, IfIdWrite=0, IdExFlush=1. This cycle is bubble 1.
  - If LOAD_BUBBLES>1: bub_cnt←LOAD_BUBBLES-1, state←LU_STALL.
- LU_STALL: same outputs as a load-use cycle, and load_use is ignored.
  - bub_cnt decrements each cycle.
  - When bub_cnt==1, state←RUN.
- StallCnt increments on every cycle with PcWrite=0 (freeze and bubbles) and saturates at 16'hFFFF.

## Timing
- Reset (rst_i=1, asynchronous):
  - state=RUN; bub_cnt, wait_cnt and StallCnt are 0; MemTimeout=0.
  - Forced outputs while rst_i=1: PcWrite=IfIdWrite=StageEn=0, all flushes=1.
- The first cycle after rst_i falls follows normal RUN rules.
- Reset mid-LU_STALL or mid-MEM_WAIT abandons the operation immediately.
- Zero-latency response: a hazard affects the enables in the same cycle it is presented. State changes take effect on the next edge.
- Load-use with LOAD_BUBBLES=N: PcWrite=0 for exactly N consecutive unfrozen cycles. Frozen cycles do not consume bubbles.
- Branch during freeze: ignored until the release cycle. MEM is held, so BranchTaken is still asserted then, and the flush fires in the release cycle.
- Simultaneous BranchTaken and load_use: only the flush occurs. IfIdFlush=1, no stall, and StallCnt is unchanged.
- MemReq & MemReady in the same cycle: no freeze and no state change.

## Test plan
- Load-use, LOAD_BUBBLES=1: ExeMemRead=1, ExeRt=8, IdRs=8 for one cycle → PcWrite=IfIdWrite=0 and IdExFlush=1 for 1 cycle; state stays RUN; StallCnt=1.
- LOAD_BUBBLES=3, ExeRt=9, IdRt=9, IdUsesRt=1 → 3 bubble cycles, RUN afterwards, StallCnt=3.
  - Same stimulus with IdUsesRt=0 → no stall.
  - Same stimulus with ExeRt=0 → no stall.
- Memory wait: MemReq=1, MemReady=0 for 4 cycles, then MemReady=1 → StageEn=0 for 4 cycles and 1 on the 5th; StallCnt=4.
  - Issue this in the middle of a 3-bubble stall → remaining bubbles resume after release.
- Branch in LU_STALL (LOAD_BUBBLES=3, BranchTaken on the 2nd bubble) → all three flushes=1 and PcWrite=1 that cycle; next cycle RUN, no further bubbles.
- Timeout, MEM_TIMEOUT=5: MemReq=1, MemReady=0 held → MemTimeout rises after wait_cnt reaches 5. It stays 1 after MemReady=1 and clears only on rst_i.
- Async reset mid-MEM_WAIT → outputs take their reset values without a clock edge; StallCnt=0. Also drive 70000 freeze cycles → StallCnt=16'hFFFF, with no wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flushes and
// data-memory wait freezes, with a saturating stall counter and sticky timeout.
module hazard_ctrl #(
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned WAIT_W       = 8,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  IdRs,
   input  logic [4:0]  IdRt,
   input  logic        IdUsesRt,
   input  logic [4:0]  ExeRt,
   input  logic        ExeMemRead,
   input  logic        BranchTaken,
   input  logic        MemReq,
   input  logic        MemReady,
   output logic        PcWrite,
   output logic        IfIdWrite,
   output logic        IfIdFlush,
   output logic        IdExFlush,
   output logic        ExMemFlush,
   output logic        StageEn,
   output logic        MemTimeout,
   output logic [15:0] StallCnt
);

   localparam int unsigned BUB_W = (LOAD_BUBBLES > 1) ? $clog2(LOAD_BUBBLES + 1) : 1;

   typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

   state_e              r_state, w_state_d, r_ret_state, w_ret_d, w_eff;
   logic [BUB_W-1:0]    r_bub_cnt, w_bub_d;
   logic [WAIT_W-1:0]   r_wait_cnt, w_wait_d;
   logic                r_timeout, w_timeout_d;
   logic [15:0]         r_stall_cnt, w_stall_d;
   logic                w_freeze, w_load_use;
   logic                w_pc, w_ifid, w_stage, w_ifid_fl, w_idex_fl, w_exmem_fl;

   // While waiting, only MemReady releases; the held MEM stage keeps MemReq asserted.
   assign w_freeze   = (r_state == StMemWait) ? ~MemReady : (MemReq & ~MemReady);
   assign w_eff      = (r_state == StMemWait) ? r_ret_state : r_state;
   assign w_load_use = ExeMemRead && (ExeRt != 5'd0) &&
                       ((ExeRt == IdRs) || (IdUsesRt && (ExeRt == IdRt)));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= StRun;
         r_ret_state <= StRun;
         r_bub_cnt   <= '0;
         r_wait_cnt  <= '0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_d;
         r_ret_state <= w_ret_d;
         r_bub_cnt   <= w_bub_d;
         r_wait_cnt  <= w_wait_d;
         r_timeout   <= w_timeout_d;
         r_stall_cnt <= w_stall_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_ret_d     = r_ret_state;
      w_bub_d     = r_bub_cnt;
      w_wait_d    = r_wait_cnt;
      w_timeout_d = r_timeout;
      if (w_freeze) begin
         if (r_state != StMemWait) begin
            w_ret_d   = r_state;
            w_wait_d  = WAIT_W'(1);
            w_state_d = StMemWait;
         end else begin
            if (r_wait_cnt != '1) w_wait_d = r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) w_timeout_d = 1'b1;
         end
      end else begin
         w_state_d = w_eff;
         if (BranchTaken) begin
            w_state_d = StRun;
            w_bub_d   = '0;
         end else if (w_eff == StLuStall) begin
            w_bub_d = r_bub_cnt - BUB_W'(1);
            if (r_bub_cnt == BUB_W'(1)) w_state_d = StRun;
         end else if (w_eff == StRun && w_load_use && LOAD_BUBBLES > 1) begin
            w_bub_d   = BUB_W'(LOAD_BUBBLES - 1);
            w_state_d = StLuStall;
         end
      end
      w_stall_d = (!w_pc && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
   end

   always_comb begin
      w_pc       = 1'b1;
      w_ifid     = 1'b1;
      w_stage    = 1'b1;
      w_ifid_fl  = 1'b0;
      w_idex_fl  = 1'b0;
      w_exmem_fl = 1'b0;
      if (w_freeze) begin
         w_pc    = 1'b0;
         w_ifid  = 1'b0;
         w_stage = 1'b0;
      end else if (BranchTaken) begin
         w_ifid_fl  = 1'b1;
         w_idex_fl  = 1'b1;
         w_exmem_fl = 1'b1;
      end else if (w_eff == StLuStall || (w_eff == StRun && w_load_use)) begin
         w_pc      = 1'b0;
         w_ifid    = 1'b0;
         w_idex_fl = 1'b1;
      end
   end

   assign PcWrite    = ~rst_i & w_pc;
   assign IfIdWrite  = ~rst_i & w_ifid;
   assign StageEn    = ~rst_i & w_stage;
   assign IfIdFlush  = rst_i | w_ifid_fl;
   assign IdExFlush  = rst_i | w_idex_fl;
   assign ExMemFlush = rst_i | w_exmem_fl;
   assign MemTimeout = r_timeout;
   assign StallCnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_BUBBLES=1 and one with
// LOAD_BUBBLES=3, MEM_TIMEOUT=5, both fed from the same stimulus.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, exe_rt = '0;
   logic id_uses_rt = 0, exe_mem_read = 0, branch = 0, mem_req = 0, mem_ready = 0;

   logic a_pc, a_ifid, a_iffl, a_idfl, a_exfl, a_stage, a_to;
   logic b_pc, b_ifid, b_iffl, b_idfl, b_exfl, b_stage, b_to;
   logic [15:0] a_cnt, b_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_BUBBLES(1), .WAIT_W(8), .MEM_TIMEOUT(255)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .IdRs(id_rs), .IdRt(id_rt), .IdUsesRt(id_uses_rt),
      .ExeRt(exe_rt), .ExeMemRead(exe_mem_read), .BranchTaken(branch),
      .MemReq(mem_req), .MemReady(mem_ready), .PcWrite(a_pc), .IfIdWrite(a_ifid),
      .IfIdFlush(a_iffl), .IdExFlush(a_idfl), .ExMemFlush(a_exfl), .StageEn(a_stage),
      .MemTimeout(a_to), .StallCnt(a_cnt)
   );

   hazard_ctrl #(.LOAD_BUBBLES(3), .WAIT_W(8), .MEM_TIMEOUT(5)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .IdRs(id_rs), .IdRt(id_rt), .IdUsesRt(id_uses_rt),
      .ExeRt(exe_rt), .ExeMemRead(exe_mem_read), .BranchTaken(branch),
      .MemReq(mem_req), .MemReady(mem_ready), .PcWrite(b_pc), .IfIdWrite(b_ifid),
      .IfIdFlush(b_iffl), .IdExFlush(b_idfl), .ExMemFlush(b_exfl), .StageEn(b_stage),
      .MemTimeout(b_to), .StallCnt(b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_in();
      id_rs = '0; id_rt = '0; exe_rt = '0; id_uses_rt = 0; exe_mem_read = 0;
      branch = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      #1 rst = 1'b0;
      tick();
   endtask

   task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] ert);
      id_rs = rs; id_rt = rt; id_uses_rt = uses; exe_rt = ert; exe_mem_read = 1'b1;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      check("rst_pc", b_pc, 0);
      check("rst_ifid", b_ifid, 0);
      check("rst_stage", b_stage, 0);
      check("rst_flushes", {b_iffl, b_idfl, b_exfl}, 3'b111);
      check("rst_cnt", b_cnt, 0);
      check("rst_to", b_to, 0);
      tick();
      rst = 1'b0;
      #1 check("run_pc", b_pc, 1);
      check("run_stage", b_stage, 1);
      tick();

      // Single-bubble load-use on rs
      set_lu(5'd8, 5'd0, 1'b0, 5'd8);
      #1 check("lu1_pc", a_pc, 0);
      check("lu1_ifid", a_ifid, 0);
      check("lu1_idexfl", a_idfl, 1);
      tick();
      clear_in();
      #1 check("lu1_after_pc", a_pc, 1);
      check("lu1_cnt", a_cnt, 1);
      tick();

      // Three-bubble load-use on rt
      do_reset();
      set_lu(5'd0, 5'd9, 1'b1, 5'd9);
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("lu3_pc_%0d", i), b_pc, 0);
         check($sformatf("lu3_idexfl_%0d", i), b_idfl, 1);
         tick();
         clear_in();
      end
      #1 check("lu3_after_pc", b_pc, 1);
      check("lu3_cnt", b_cnt, 3);
      tick();

      do_reset();
      set_lu(5'd0, 5'd9, 1'b0, 5'd9);
      #1 check("lu_nouse_pc", b_pc, 1);
      tick();
      clear_in();
      set_lu(5'd0, 5'd0, 1'b1, 5'd0);
      #1 check("lu_r0_pc", b_pc, 1);
      tick();
      clear_in();
      #1 check("lu_none_cnt", b_cnt, 0);

      // Memory wait of 4 cycles
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("mw_stage_%0d", i), b_stage, 0);
         check($sformatf("mw_pc_%0d", i), b_pc, 0);
         check($sformatf("mw_fl_%0d", i), {b_iffl, b_idfl, b_exfl}, 0);
         tick();
      end
      mem_ready = 1;
      #1 check("mw_rel_stage", b_stage, 1);
      check("mw_rel_pc", b_pc, 1);
      tick();
      clear_in();
      #1 check("mw_cnt", b_cnt, 4);

      // Memory wait in the middle of a 3-bubble stall
      do_reset();
      set_lu(5'd7, 5'd0, 1'b0, 5'd7);
      #1 check("mix_b1_pc", b_pc, 0);
      tick();
      clear_in();
      mem_req = 1;
      for (int i = 0; i < 2; i++) begin
         #1 check($sformatf("mix_frz_stage_%0d", i), b_stage, 0);
         check($sformatf("mix_frz_idfl_%0d", i), b_idfl, 0);
         tick();
      end
      mem_ready = 1;
      #1 check("mix_b2_pc", b_pc, 0);
      check("mix_b2_idfl", b_idfl, 1);
      check("mix_b2_stage", b_stage, 1);
      tick();
      clear_in();
      #1 check("mix_b3_pc", b_pc, 0);
      tick();
      #1 check("mix_done_pc", b_pc, 1);
      check("mix_cnt", b_cnt, 5);

      // Branch on the second bubble aborts the stall
      do_reset();
      set_lu(5'd4, 5'd0, 1'b0, 5'd4);
      tick();
      clear_in();
      branch = 1;
      #1 check("br_pc", b_pc, 1);
      check("br_flushes", {b_iffl, b_idfl, b_exfl}, 3'b111);
      tick();
      clear_in();
      #1 check("br_after_pc", b_pc, 1);
      check("br_cnt", b_cnt, 1);

      // Branch together with load-use: flush only
      do_reset();
      set_lu(5'd4, 5'd0, 1'b0, 5'd4);
      branch = 1;
      #1 check("brlu_pc", b_pc, 1);
      check("brlu_iffl", b_iffl, 1);
      tick();
      clear_in();
      #1 check("brlu_cnt", b_cnt, 0);
      check("brlu_after_pc", b_pc, 1);

      // Timeout, branch held through the freeze
      do_reset();
      mem_req = 1; branch = 1;
      #1 check("brfrz_iffl", b_iffl, 0);
      check("brfrz_pc", b_pc, 0);
      for (int i = 0; i < 5; i++) tick();
      #1 check("to_before", b_to, 0);
      tick();
      #1 check("to_set", b_to, 1);
      check("to_a_clear", a_to, 0);
      mem_ready = 1;
      #1 check("brrel_iffl", b_iffl, 1);
      check("brrel_pc", b_pc, 1);
      tick();
      branch = 0; mem_ready = 0;
      #1 check("to_sticky", b_to, 1);
      tick();
      // Async reset while in MEM_WAIT
      #2 rst = 1'b1;
      #1 check("arst_pc", b_pc, 0);
      check("arst_iffl", b_iffl, 1);
      check("arst_cnt", b_cnt, 0);
      check("arst_to", b_to, 0);
      clear_in();
      tick();
      rst = 1'b0;
      #1 check("arst_run_stage", b_stage, 1);
      check("arst_run_pc", b_pc, 1);
      tick();

      // Stall-counter saturation
      mem_req = 1;
      for (int i = 0; i < 70000; i++) tick();
      #1 check("sat_cnt", b_cnt, 16'hFFFF);
      tick();
      #1 check("sat_hold", b_cnt, 16'hFFFF);
      clear_in();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
